// File: rtl/mem_access_unit.sv
// Data-memory initiator: handshaked byte/half/word loads and stores against a big-endian word port.
// Define MEM_ACC_STATS_EN to add the stat_loads/stat_stores/stat_errs access counters.
module mem_access_unit #(
   parameter int MEM_BYTES  = 16384,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data,
   output logic                  mem_MemWrite,
   output logic                  mem_MemRead
`ifdef MEM_ACC_STATS_EN
   ,
   output logic [31:0]           stat_loads,
   output logic [31:0]           stat_stores,
   output logic [31:0]           stat_errs
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  write_q, write_d;
   logic [1:0]            size_q, size_d;
   logic                  uns_q, uns_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           old_q, old_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;

   logic                  req_misaligned, req_out_of_range;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [31:0]           ld_ext;
   logic [31:0]           merged;

   assign req_misaligned   = (req_size == 2'd3) ||
                             (req_size == 2'd1 && req_addr[0]) ||
                             (req_size == 2'd2 && req_addr[1:0] != 2'b00);
   assign req_out_of_range = req_addr >= ADDR_WIDTH'(MEM_BYTES);

   // Big-endian lanes: byte offset 0 is the most significant byte of the word.
   always_comb begin
      ld_byte = 8'h00;
      case (addr_q[1:0])
         2'd0: ld_byte = mem_read_data[31:24];
         2'd1: ld_byte = mem_read_data[23:16];
         2'd2: ld_byte = mem_read_data[15:8];
         default: ld_byte = mem_read_data[7:0];
      endcase
      ld_half = addr_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];
      case (size_q)
         2'd0:    ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
         2'd1:    ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
         default: ld_ext = mem_read_data;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         always_comb begin
            if (size_q == 2'd2)
               merged[31-8*gi -: 8] = wdata_q[31-8*gi -: 8];
            else if (size_q == 2'd1)
               merged[31-8*gi -: 8] = (addr_q[1] == LANE[1]) ? wdata_q[15-8*(gi%2) -: 8]
                                                             : old_q[31-8*gi -: 8];
            else
               merged[31-8*gi -: 8] = (addr_q[1:0] == LANE) ? wdata_q[7:0]
                                                            : old_q[31-8*gi -: 8];
         end
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      old_d        = old_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      req_ready    = 1'b0;
      mem_MemRead  = 1'b0;
      mem_MemWrite = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d = req_write;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (req_misaligned || req_out_of_range) begin
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
                  state_d = S_RESP;
               end else if (req_write && req_size == 2'd2) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            mem_MemRead = 1'b1;
            old_d       = mem_read_data;
            if (write_q) begin
               state_d = S_WR;
            end else begin
               rdata_d = ld_ext;
               err_d   = 1'b0;
               state_d = S_RESP;
            end
         end
         S_WR: begin
            mem_MemWrite = 1'b1;
            rdata_d      = 32'h0;
            err_d        = 1'b0;
            state_d      = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         write_q <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         old_q   <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         old_q   <= old_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign resp_valid     = (state_q == S_RESP);
   assign resp_rdata     = rdata_q;
   assign resp_err       = err_q;
   assign mem_address    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_write_data = (state_q == S_WR) ? merged : 32'h0;

`ifdef MEM_ACC_STATS_EN
   logic [31:0] stat_loads_q, stat_stores_q, stat_errs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_loads_q  <= 32'h0;
         stat_stores_q <= 32'h0;
         stat_errs_q   <= 32'h0;
      end else if (state_q == S_RESP) begin
         if (err_q)        stat_errs_q   <= stat_errs_q + 32'd1;
         else if (write_q) stat_stores_q <= stat_stores_q + 32'd1;
         else              stat_loads_q  <= stat_loads_q + 32'd1;
      end
   end

   assign stat_loads  = stat_loads_q;
   assign stat_stores = stat_stores_q;
   assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface; sits between the CPU MEM stage and the byte-addressable, big-endian, word-port data memory.
- Data memory characteristics: combinational read, write on clk edge.
- Accepts lb/lbu/lh/lhu/lw/sb/sh/sw requests with a valid/ready handshake.
- Extracts and sign/zero-extends load data; performs read-modify-write for sub-word stores; flags misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 16384, data memory size in bytes; an access with req_addr >= MEM_BYTES is out of range.
- ADDR_WIDTH, 32, width of request and memory addresses.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  CPU request present.
- req_ready  output  1  unit in IDLE and able to accept; the CPU stalls while low.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned.
- req_unsigned  input  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: access complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range; valid with resp_valid.
- mem_address  output  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2],2'b00}).
- mem_write_data  output  32  big-endian word to memory.
- mem_read_data  input  32  combinational word from memory.
- mem_MemWrite  output  1  memory write strobe.
- mem_MemRead  output  1  memory read enable.

Behaviour:
- Reset: asynchronous, active-low (rst_n). State goes to IDLE. req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0.
- Memory controls during reset: mem_MemRead and mem_MemWrite are decoded from state, so they drop to 0 immediately on reset assertion. mem_address=0, mem_write_data=0.
- FSM states: IDLE, RD, WR, RESP.
- Request capture in IDLE: when req_valid=1, latch write, size, unsigned, addr and wdata. Then check for errors:
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0, or size=3.
  - out of range: addr >= MEM_BYTES.
- Error request: go to RESP with resp_err=1. No memory strobe is asserted at any point.
- Load (no error): IDLE -> RD -> RESP.
  - In RD: mem_MemRead=1. Register mem_read_data at the end of the cycle.
- Word store: IDLE -> WR -> RESP.
  - In WR: mem_MemWrite=1 and mem_write_data=wdata.
- Byte or half store: IDLE -> RD -> WR -> RESP (read-modify-write).
  - In RD: read and capture the old word.
  - In WR: write the old word with only the target lane(s) replaced.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_ready is 0 in RD, WR and RESP.
- Latency from the accept edge to the resp_valid cycle: lw/lb/lh 2 cycles; sw 2; sb/sh 3; error 1.
- Byte lanes (big-endian): byte offset k occupies word bits [31-8k : 24-8k].
  - Half offset 0 is [31:16]; half offset 2 is [15:0].
  - Load extension uses bit 7 (byte) or bit 15 (half) of the extracted field.
- Response outputs: resp_rdata and resp_err are registered. They hold their values outside RESP, except that resp_rdata=0 on stores and errors.
- Simultaneous events: req_valid while busy is ignored (ready=0). The CPU must hold the request stable until accepted.
- Reset mid-RMW (in WR): the write is abandoned and memory keeps its old contents, since the strobe has not yet been sampled by clk.

Optional Feature:
- Macro: MEM_ACC_STATS_EN.
- Defined: adds three outputs, stat_loads, stat_stores and stat_errs, each 32 bits.
  - Each increments in the RESP cycle of a completed load, store or error respectively.
  - Each wraps from 0xFFFFFFFF to 0 and resets to 0 on rst_n.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-transaction: assert rst_n=0 during WR of an sb -> mem_MemWrite drops the same cycle, the memory word is unchanged, and req_ready=1 after release.
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> memory bytes 0x10..0x13 = DE,AD,BE,EF; resp_rdata=0xDEADBEEF at accept+2; resp_err=0.
- Byte store via RMW: with word 0x11223344 @0x20, sb 0xAA @0x22 -> exactly one RD cycle then one WR cycle; word becomes 0x1122AA44; resp_valid at accept+3.
- Load extension: with word 0x80FF7F01 @0x40:
  - lb @0x40 -> 0xFFFFFF80; lbu @0x40 -> 0x00000080.
  - lh @0x42 -> 0x00007F01; lh @0x40 -> 0xFFFF80FF.
- Errors: lw @0x41 and sh @0x3FFF -> resp_err=1 at accept+1; mem_MemRead and mem_MemWrite never asserted. lw @0x4000 -> resp_err=1.
- Stats (macro defined): 3 loads, 2 stores and 1 error -> stat_loads=3, stat_stores=2, stat_errs=1. Preloading a counter to 0xFFFFFFFF (force) and completing one access -> counter reads 0.
